// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-memory write bundle for instr_encoder
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_kind;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [15:0]       req_imm;
    logic [25:0]       req_target;
    logic              seal;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   wr_count;
    logic              full;
    logic              done;
    logic              err_illegal;

    modport master (
        output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target, seal,
        input  req_ready, im_we, im_addr, im_wdata, wr_count, full, done, err_illegal
    );

    modport slave (
        input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target, seal,
        output req_ready, im_we, im_addr, im_wdata, wr_count, full, done, err_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS subset encoder writing sequential words into instruction memory
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_encoder_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, TERM, DONE} state_t;

    localparam logic [31:0] TERM_WORD = 32'h1000FFFF;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              legal;
    logic [31:0]       enc_word;

    assign bus.req_ready = (state == IDLE) && !bus.full;
    assign bus.full      = bus.wr_count[ADDR_W];
    assign bus.done      = (state == DONE);
    assign legal         = (bus.req_kind <= 4'd10);

    // Each format builds its word from scratch so unused request fields never leak.
    always_comb begin
        enc_word = 32'h0;
        case (bus.req_kind)
            4'd1:    enc_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'b100001};
            4'd2:    enc_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'b100011};
            4'd3:    enc_word = {6'b001101, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd4:    enc_word = {6'b100011, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd5:    enc_word = {6'b101011, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd6:    enc_word = {6'b000100, bus.req_rs, bus.req_rt, bus.req_imm};
            4'd7:    enc_word = {6'b001111, 5'd0, bus.req_rt, bus.req_imm};
            4'd8:    enc_word = {6'b000010, bus.req_target};
            4'd9:    enc_word = {6'b000011, bus.req_target};
            4'd10:   enc_word = {6'b000000, bus.req_rs, 15'd0, 6'b001000};
            default: enc_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            bus.im_we       <= 1'b0;
            bus.im_addr     <= '0;
            bus.im_wdata    <= 32'h0;
            bus.wr_count    <= '0;
            bus.err_illegal <= 1'b0;
        end else begin
            bus.im_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        if (legal) begin
                            bus.im_we    <= 1'b1;
                            bus.im_addr  <= ptr;
                            bus.im_wdata <= enc_word;
                            ptr          <= ptr + 1'b1;
                            bus.wr_count <= bus.wr_count + 1'b1;
                        end else begin
                            bus.err_illegal <= 1'b1;
                        end
                    end else if (!bus.req_valid && bus.seal) begin
                        state <= bus.full ? DONE : TERM;
                    end
                end
                TERM: begin
                    bus.im_we    <= 1'b1;
                    bus.im_addr  <= ptr;
                    bus.im_wdata <= TERM_WORD;
                    ptr          <= ptr + 1'b1;
                    bus.wr_count <= bus.wr_count + 1'b1;
                    state        <= DONE;
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Converts mnemonic-level instruction requests into 32-bit MIPS machine words for the supported subset: nop, addu, subu, ori, lw, sw, beq, lui, j, jal, jr. Writes the words sequentially into the instruction-memory write port. It is the encoding counterpart of the pipeline's instruction decoder and is used for self-loading test programs and boot images. A seal operation appends a self-loop terminator and locks the block.

Parameters:
ADDR_W, 10, IM word-address width; capacity is 2^ADDR_W words.

Ports:
clk  input  1  system clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  an instruction request is present.
req_ready  output  1  the block accepts a request this cycle.
req_kind  input  4  mnemonic: 0 nop, 1 addu, 2 subu, 3 ori, 4 lw, 5 sw, 6 beq, 7 lui, 8 j, 9 jal, 10 jr; 11-15 illegal.
req_rs  input  5  rs field.
req_rt  input  5  rt field.
req_rd  input  5  rd field.
req_imm  input  16  imm16 / branch offset.
req_target  input  26  jump index.
seal  input  1  append the terminator and lock.
im_we  output  1  IM write strobe.
im_addr  output  ADDR_W  IM word address.
im_wdata  output  32  encoded word.
wr_count  output  ADDR_W+1  number of words written.
full  output  1  wr_count == 2^ADDR_W.
done  output  1  sealed; no further writes.
err_illegal  output  1  sticky flag: an illegal kind was consumed.

Behaviour:
- Reset values: state IDLE; im_we=0, im_addr=0, im_wdata=0, wr_count=0, full=0, done=0, err_illegal=0.
- States:
  - IDLE: normal operation.
  - TERM: emit the terminator.
  - DONE: locked.
- req_ready = (state==IDLE) && !full. Combinational, no dependence on req_valid.
- A request is accepted when req_valid && req_ready at edge N.
  - Legal kind: at cycle N+1, im_we=1, im_addr=ptr, im_wdata=encoded word. The pointer and wr_count increment at the N+1 edge.
  - Back-to-back acceptance gives one write per cycle (throughput 1).
- im_we is a single-cycle registered pulse. im_addr and im_wdata hold their last values while im_we=0.
- Encoding, with op = bits 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0:
  - addu: op 000000, funct 100001.
  - subu: op 000000, funct 100011.
  - jr: op 000000, funct 001000; rt, rd and shamt forced to 0.
  - nop: 0x00000000; all request fields ignored.
  - ori: op 001101, rs/rt/imm.
  - lw: op 100011, rs/rt/imm.
  - sw: op 101011, rs/rt/imm.
  - beq: op 000100, rs/rt/imm.
  - lui: op 001111, rs forced to 0.
  - j: op 000010, target.
  - jal: op 000011, target.
  - R-type shamt is always 0. Fields not used by a format are zeroed and never leak through.
- Illegal kind (11-15): the request is consumed (ready stays high), nothing is written, and err_illegal is set to 1 until reset.
- Full: after the write that makes wr_count = 2^ADDR_W, full=1 and req_ready=0. The pointer wraps to 0 internally but is never used again.
- Seal:
  - Sampled in IDLE only when req_valid=0. If req_valid and seal are both high, the request is served and seal is ignored that cycle (the source must hold seal).
  - Seal while not full: IDLE -> TERM. TERM issues im_we=1 with word 0x1000FFFF (beq $0,$0,-1) at ptr, increments wr_count, then goes to DONE.
  - Seal while full: IDLE -> DONE directly; no write.
- DONE: req_ready=0, done=1, no writes. Only reset exits.
- Reset asserted mid-operation, including during TERM: the next edge returns everything to reset values. Any pending write is dropped.

Test Plan:
- Reset then a request addu rs=1 rt=2 rd=3 -> one cycle later im_we=1, im_addr=0, im_wdata=0x00221821; wr_count=1.
- Back-to-back requests ori rt=1 rs=0 imm=0x1234, lw rs=1 rt=2 imm=4, jal target=0x0C00 -> consecutive writes at addresses 0,1,2 with words 0x34011234, 0x8C220004, 0x0C000C00; req_ready stays 1.
- lui rs=7 rt=5 imm=0xABCD -> 0x3C05ABCD (rs zeroed). jr rs=31 rt=9 rd=4 -> 0x03E00008.
- req_kind=12 -> no im_we, err_illegal=1 persists; a following nop writes 0x00000000 at the same address.
- ADDR_W=2: four writes -> full=1, req_ready=0. Seal -> done=1 with no fifth write. A further req_valid is ignored.
- After 2 writes, assert seal with req_valid=0 -> im_addr=2, im_wdata=0x1000FFFF, wr_count=3, then done=1. Pulsing reset mid-TERM clears all outputs to 0.
